// File: rtl/aes_encipher_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_encipher_round
// Purpose  : Iterative AES-128/256 encryption round datapath; one round per
//            five cycles (four shared S-box word lookups, then one
//            ShiftRows/MixColumns/AddRoundKey cycle).
// Revision : 1.0  initial release
// ============================================================================
module aes_encipher_round #(
   parameter int AES_128_NUM_ROUNDS = 10,
   parameter int AES_256_NUM_ROUNDS = 14
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         next,
   input  logic         keylen,
   input  logic [127:0] block,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   output logic [31:0]  sboxw,
   input  logic [31:0]  new_sboxw,
   output logic [127:0] new_block,
   output logic         ready
);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_init = 2'd1;
   localparam logic [1:0] c_sbox = 2'd2;
   localparam logic [1:0] c_main = 2'd3;

   localparam logic [3:0] c_nr_128 = 4'(AES_128_NUM_ROUNDS);
   localparam logic [3:0] c_nr_256 = 4'(AES_256_NUM_ROUNDS);

   logic [1:0]   r_state;
   logic [1:0]   w_state_next;
   logic [127:0] r_block;
   logic [3:0]   r_round_ctr;
   logic [1:0]   r_sword_ctr;
   logic         r_keylen;
   logic [3:0]   w_num_rounds;
   logic         w_final_round;
   logic [127:0] w_shifted;
   logic [127:0] w_mixed;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte (row r, column c) sits at byte index 4c+r, MSB first.
   function automatic logic [127:0] shift_rows(input logic [127:0] b);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = b[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   assign w_num_rounds  = r_keylen ? c_nr_256 : c_nr_128;
   assign w_final_round = (r_round_ctr >= w_num_rounds);
   assign w_shifted     = shift_rows(r_block);
   assign w_mixed       = {mix_column(w_shifted[127:96]), mix_column(w_shifted[95:64]),
                           mix_column(w_shifted[63:32]),  mix_column(w_shifted[31:0])};

   assign round     = r_round_ctr;
   assign new_block = r_block;

   always_comb begin
      sboxw = r_block[127:96];
      case (r_sword_ctr)
         2'd0:    sboxw = r_block[127:96];
         2'd1:    sboxw = r_block[95:64];
         2'd2:    sboxw = r_block[63:32];
         default: sboxw = r_block[31:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (next) w_state_next = c_init;
         c_init:  w_state_next = c_sbox;
         c_sbox:  if (r_sword_ctr == 2'd3) w_state_next = c_main;
         c_main:  w_state_next = w_final_round ? c_idle : c_sbox;
         default: w_state_next = c_idle;
      endcase
   end

   always_comb begin
      ready = (r_state == c_idle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_block     <= '0;
         r_round_ctr <= '0;
         r_sword_ctr <= '0;
         r_keylen    <= 1'b0;
      end else begin
         case (r_state)
            c_idle: begin
               if (next) begin
                  r_keylen    <= keylen;
                  r_round_ctr <= '0;
               end
            end
            c_init: begin
               r_block     <= block ^ round_key;
               r_round_ctr <= 4'd1;
               r_sword_ctr <= 2'd0;
            end
            c_sbox: begin
               case (r_sword_ctr)
                  2'd0:    r_block[127:96] <= new_sboxw;
                  2'd1:    r_block[95:64]  <= new_sboxw;
                  2'd2:    r_block[63:32]  <= new_sboxw;
                  default: r_block[31:0]   <= new_sboxw;
               endcase
               r_sword_ctr <= r_sword_ctr + 2'd1;
            end
            c_main: begin
               // Final round skips MixColumns and leaves the counter parked.
               if (w_final_round) begin
                  r_block <= w_shifted ^ round_key;
               end else begin
                  r_block     <= w_mixed ^ round_key;
                  r_round_ctr <= r_round_ctr + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_encipher_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encipher_round
// Purpose  : Self-checking bench for aes_encipher_round with key memory and
//            S-box models plus a byte-level AES reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_aes_encipher_round;

   logic         clk = 1'b0;
   logic         reset;
   logic         next;
   logic         keylen;
   logic [127:0] block;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic [31:0]  sboxw;
   logic [31:0]  new_sboxw;
   logic [127:0] new_block;
   logic         ready;

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox_tab [256];
   logic [127:0] rk [16];

   typedef struct {
      logic         kl;
      logic [255:0] key;
      logic [127:0] pt;
      logic [127:0] init_exp;
      logic [127:0] ct_exp;
   } vec_t;

   vec_t vecs [6];

   localparam logic [255:0] c_key_c1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] c_key_c3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] c_pt     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] c_init   = 128'h00102030405060708090a0b0c0d0e0f0;
   localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] c_ct_c3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_encipher_round dut (
      .clk       (clk),
      .reset     (reset),
      .next      (next),
      .keylen    (keylen),
      .block     (block),
      .round     (round),
      .round_key (round_key),
      .sboxw     (sboxw),
      .new_sboxw (new_sboxw),
      .new_block (new_block),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   assign round_key = rk[round];
   assign new_sboxw = {sbox_tab[sboxw[31:24]], sbox_tab[sboxw[23:16]],
                       sbox_tab[sboxw[15:8]],  sbox_tab[sboxw[7:0]]};

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   // S-box from the multiplicative inverse (b^254) and the affine map.
   task automatic build_sbox();
      for (int v = 0; v < 256; v++) begin
         logic [7:0] b, inv, s;
         b = 8'(v);
         inv = 8'h01;
         for (int e = 0; e < 254; e++) inv = gmul(inv, b);
         if (v == 0) inv = 8'h00;
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_tab[v] = s;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   task automatic expand(input logic kl, input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      int nk, nr;
      nk = kl ? 8 : 4;
      nr = kl ? 14 : 10;
      rcon = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < 4*(nr+1); i++) begin
         if (i < nk) begin
            w[i] = key[255 - 32*i -: 32];
         end else begin
            tmp = w[i-1];
            if (i % nk == 0) begin
               tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
               rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
               tmp = sub_word(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
         end
      end
      for (int r = 0; r < 16; r++) rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
   endtask

   // Byte-array reference cipher; consumes the keys currently in rk.
   function automatic logic [127:0] aes_ref(input logic kl, input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [127:0] o;
      int nr;
      nr = kl ? 14 : 10;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int r = 1; r <= nr; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
         for (int c = 0; c < 4; c++) begin
            if (r < nr) begin
               s[4*c]   = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
               s[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end else begin
               for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Waits (from the negedge after the accepting edge) until ready; returns edge count.
   task automatic wait_done(input int nr, input bit noise, input logic [127:0] init_exp,
                            input string nm, output int k);
      k = 0;
      chk({nm, " ready_fall"}, 128'(ready), 128'(1'b0));
      chk({nm, " round0"}, 128'(round), 128'(0));
      for (k = 1; k <= 120; k++) begin
         if (noise) begin
            next   = 1'($urandom);
            keylen = 1'($urandom);
            if (k >= 2) block = {$urandom, $urandom, $urandom, $urandom};
         end
         @(negedge clk);
         if (k == 1) chk({nm, " init_block"}, new_block, init_exp);
         chk({nm, " round_idx"}, 128'(round), 128'(((1 + (k-1)/5) > nr) ? nr : (1 + (k-1)/5)));
         if (ready) break;
      end
      chk({nm, " latency"}, 128'(k), 128'(5*nr + 1));
   endtask

   task automatic run(input vec_t v, input bit noise, input string nm);
      int k;
      expand(v.kl, v.key);
      @(negedge clk);
      block = v.pt; keylen = v.kl; next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      wait_done(v.kl ? 14 : 10, noise, v.init_exp, nm, k);
      next = 1'b0;
      chk({nm, " result"}, new_block, v.ct_exp);
   endtask

   initial begin
      int k;
      build_sbox();
      for (int r = 0; r < 16; r++) rk[r] = '0;

      vecs[0] = '{1'b0, c_key_c1, c_pt, c_init, c_ct_c1};
      vecs[1] = '{1'b1, c_key_c3, c_pt, c_init, c_ct_c3};
      for (int i = 2; i < 6; i++) begin
         vecs[i].kl  = 1'(i % 2);
         vecs[i].key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
         expand(vecs[i].kl, vecs[i].key);
         vecs[i].init_exp = vecs[i].pt ^ rk[0];
         vecs[i].ct_exp   = aes_ref(vecs[i].kl, vecs[i].pt);
      end

      // Reset with random inputs and next held high.
      reset = 1'b1; next = 1'b1; keylen = 1'($urandom);
      block = {$urandom, $urandom, $urandom, $urandom};
      repeat (2) @(negedge clk);
      chk("rst ready", 128'(ready), 128'(1'b1));
      chk("rst new_block", new_block, 128'h0);
      chk("rst round", 128'(round), 128'(0));
      chk("rst sboxw", 128'(sboxw), 128'(0));
      reset = 1'b0; next = 1'b0;
      @(negedge clk);
      chk("rst no_accept", 128'(ready), 128'(1'b1));

      // Reference cross-check of the fixed vectors.
      expand(1'b0, c_key_c1);
      chk("model c1", aes_ref(1'b0, c_pt), c_ct_c1);

      for (int i = 0; i < 6; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));

      run(vecs[0], 1'b1, "busy_noise");

      // Back-to-back with next held high.
      expand(1'b0, c_key_c1);
      @(negedge clk);
      block = c_pt; keylen = 1'b0; next = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         wait_done(10, 1'b0, c_init, $sformatf("b2b%0d", r), k);
         chk($sformatf("b2b%0d result", r), new_block, c_ct_c1);
         if (r == 0) begin
            @(negedge clk);
         end
      end
      next = 1'b0;
      @(negedge clk);
      chk("b2b idle", 128'(ready), 128'(1'b1));

      // Mid-run reset during round 5 S-box phase.
      expand(1'b0, c_key_c1);
      block = c_pt; keylen = 1'b0; next = 1'b1;
      @(negedge clk);
      next = 1'b0;
      repeat (22) @(negedge clk);
      chk("mid round5", 128'(round), 128'(5));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid ready", 128'(ready), 128'(1'b1));
      chk("mid new_block", new_block, 128'h0);
      chk("mid round", 128'(round), 128'(0));
      chk("mid sboxw", 128'(sboxw), 128'(0));
      run(vecs[0], 1'b0, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_encipher_round.md
# aes_encipher_round

Iterative AES encryption datapath that consumes the round keys produced by the key expansion memory. It drives the round index toward that memory and reads back the matching 128-bit round key. It shares the single 32-bit S-box word port, on the opposite side of the key expander's `sboxw`/`new_sboxw` pair. It runs one round per five cycles: four S-box word lookups, then one ShiftRows/MixColumns/AddRoundKey cycle.

## Interface
- `AES_128_NUM_ROUNDS`, default 10, round count for 128-bit keys.
- `AES_256_NUM_ROUNDS`, default 14, round count for 256-bit keys.

Ports:
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `next`  in  1  start pulse; sampled only in IDLE.
- `keylen`  in  1  0 = AES-128, 1 = AES-256; latched when `next` is accepted.
- `block`  in  128  plaintext; sampled in the INIT cycle.
- `round`  out  4  round index presented to the key memory.
- `round_key`  in  128  key for `round`, combinational in the same cycle.
- `sboxw`  out  32  word sent to the shared S-box.
- `new_sboxw`  in  32  S-box output for `sboxw`, combinational in the same cycle.
- `new_block`  out  128  ciphertext; valid while `ready` = 1 after a run.
- `ready`  out  1  1 = idle, result valid.

## Operation
- State: `block_reg`[127:0] (word0 = [127:96] … word3 = [31:0]), `round_ctr`[3:0], `sword_ctr`[1:0], latched `keylen_reg`, FSM.
- Output mapping:
  - `round` = `round_ctr`.
  - `new_block` = `block_reg`.
  - `sboxw` = `block_reg` word[`sword_ctr`].
- `num_rounds` = 10 if `keylen_reg` = 0, else 14.
- FSM states:
  - IDLE:
    - If `next` = 1: `ready` <= 0, `keylen_reg` <= `keylen`, `round_ctr` <= 0, go to INIT.
    - Otherwise hold state.
  - INIT:
    - `block_reg` <= `block` ^ `round_key` (round 0).
    - `round_ctr` <= 1, `sword_ctr` <= 0, go to SBOX.
  - SBOX:
    - Each cycle, `block_reg` word[`sword_ctr`] <= `new_sboxw`, and `sword_ctr` increments with wrap.
    - After the word3 cycle, `sword_ctr` = 0; go to MAIN.
  - MAIN, when `round_ctr` < `num_rounds`:
    - `block_reg` <= MixColumns(ShiftRows(`block_reg`)) ^ `round_key`.
    - `round_ctr` += 1, go to SBOX.
  - MAIN, when `round_ctr` = `num_rounds` (final round):
    - `block_reg` <= ShiftRows(`block_reg`) ^ `round_key`, with no MixColumns.
    - `ready` <= 1, go to IDLE.
    - `round_ctr` holds its value.
- ShiftRows: byte row r of each column is rotated left by r columns (FIPS-197 column-major byte order).
- MixColumns:
  - GF(2^8), xtime(b) = {b[6:0],0} ^ (8'h1b & {8{b[7]}}).
  - Each column transforms to [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- `keylen` changes while busy are ignored; only `keylen_reg` is used.
- `next` while not in IDLE is ignored and not queued.
- Reset values:
  - FSM = IDLE, `ready` = 1.
  - `block_reg` = 0, so `new_block` = 0 and `sboxw` = 32'h0.
  - `round_ctr` = 0 (`round` = 0), `sword_ctr` = 0, `keylen_reg` = 0.
- Reset asserted mid-run aborts immediately: next cycle shows the reset values, with no partial result flagged ready.

## Timing
- `next` is sampled high in IDLE at edge t.
  - INIT is at cycle t+1.
  - Round r SBOX occupies cycles t+5r−3 … t+5r.
  - Round r MAIN is at cycle t+5r+1.
- `ready` rises, and `new_block` is valid, at t+2+5·Nr.
  - AES-128: t+52.
  - AES-256: t+72.
- `ready` falls at t+1.
- `next` held high continuously: the cycle `ready` rises is IDLE, so a new run is accepted there and `ready` is 1 for exactly one cycle.
- `round_key` and `new_sboxw` are assumed valid combinationally in the same cycle; the block adds no registers on those paths.
- Key memory must be ready before `next`; the block does not check it.

## Test plan
- Reset:
  - Assert `reset` for 2 cycles with random inputs.
  - Require `ready` = 1, `new_block` = 0, `round` = 0, `sboxw` = 0.
  - `next` = 1 during reset is not accepted.
- FIPS-197 C.1 (AES-128):
  - Stimulus: key 000102…0f, plaintext 00112233445566778899aabbccddeeff; bench models the key memory and the S-box.
  - After INIT, `block_reg` = 00102030405060708090a0b0c0d0e0f0.
  - `ready` at t+52 with `new_block` = 69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 C.3 (AES-256):
  - Stimulus: key 000102…1f, same plaintext.
  - `ready` at t+72 with `new_block` = 8ea2b7ca516745bfeafc49904b496089.
  - `round` sweeps 0, 1 … 14.
- Busy robustness:
  - Pulse `next` and toggle `keylen` and `block` every cycle during a C.1 run.
  - Result is still 69c4e0d8…c55a at t+52.
- Back-to-back:
  - Hold `next` = 1 across two C.1 runs.
  - `ready` is high for exactly 1 cycle between runs; the second result is identical.
- Mid-run reset:
  - Assert `reset` at round 5 SBOX.
  - Next cycle: IDLE with `ready` = 1 and `new_block` = 0; a fresh C.1 run then completes correctly.
